// File: rtl/fetch_if.sv
// fetch_if: fetch-stage handshake bundle (write-stage token in, instruction memory, decode token out)
// master: fetch side; slave: surrounding pipeline and instruction memory.
// pc/fetch_pipeline_ctl_in  PC and start token from the write stage
// imem_*                    single-beat instruction-memory read port
// instr/instr_pc/fetch_pipeline_ctl_out/misaligned/timeout_err  result to decode
interface fetch_if;
  logic [31:0] pc;
  logic        fetch_pipeline_ctl_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_pipeline_ctl_out;
  logic        misaligned;
  logic        timeout_err;
  modport master (
    input  pc, fetch_pipeline_ctl_in, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, fetch_pipeline_ctl_out, misaligned, timeout_err
  );
  modport slave (
    output pc, fetch_pipeline_ctl_in, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, fetch_pipeline_ctl_out, misaligned, timeout_err
  );
endinterface

// File: rtl/fetch.sv
// fetch: rv32i instruction-fetch stage, PC token in -> single-beat imem read -> instr/PC token to decode
// clk  rising-edge clock
// rst  asynchronous active-low reset
// fif  fetch_if.master bundle (write-stage token, imem port, decode outputs)
// Optional FETCH_TIMEOUT_EN: BUSY watchdog of TIMEOUT_CYCLES cycles that aborts with NOP and timeout_err.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_8000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  fif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        ctl_q;
  logic        mis_q;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          to_q;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      ctl_q   <= 1'b0;
      mis_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      ctl_q <= 1'b0;
      case (state_q)
        IDLE: if (fif.fetch_pipeline_ctl_in) begin
          pc_q  <= fif.pc;
          mis_q <= fif.pc[1:0] != 2'b00;
`ifdef FETCH_TIMEOUT_EN
          to_q  <= 1'b0;
          cnt_q <= '0;
`endif
          if (fif.pc[1:0] == 2'b00) begin
            addr_q  <= fif.pc;
            req_q   <= 1'b1;
            state_q <= BUSY;
          end else begin
            instr_q <= NOP_INSTR;
            ctl_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        BUSY: if (fif.imem_ack) begin
          instr_q <= fif.imem_rdata;
          req_q   <= 1'b0;
          ctl_q   <= 1'b1;
          state_q <= DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        // this cycle is the TIMEOUT_CYCLES-th without ack; an ack above wins
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_q   <= cnt_q + 1'b1;
          instr_q <= NOP_INSTR;
          to_q    <= 1'b1;
          req_q   <= 1'b0;
          ctl_q   <= 1'b1;
          state_q <= DONE;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fif.imem_req               = req_q;
  assign fif.imem_addr              = addr_q;
  assign fif.instr                  = instr_q;
  assign fif.instr_pc               = pc_q;
  assign fif.fetch_pipeline_ctl_out = ctl_q;
  assign fif.misaligned             = mis_q;
`ifdef FETCH_TIMEOUT_EN
  assign fif.timeout_err            = to_q;
`else
  assign fif.timeout_err            = 1'b0;
`endif
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scoreboard bench for the fetch stage
module tb_fetch;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
    logic        to;
  } exp_t;
  logic clk;
  logic rst;
  fetch_if fif ();
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_req = 0;
  logic prev_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
  fetch #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .fif(fif));
`else
  fetch dut (.clk(clk), .rst(rst), .fif(fif));
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) prev_req = 1'b0;
    else begin
      if (fif.imem_req && !prev_req) n_req++;
      prev_req = fif.imem_req;
      if (fif.fetch_pipeline_ctl_out) begin
        n_out++;
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_instr", fif.instr, e.instr);
          chk("sb_instr_pc", fif.instr_pc, e.pc);
          chk("sb_misaligned", 32'(fif.misaligned), 32'(e.mis));
          chk("sb_timeout_err", 32'(fif.timeout_err), 32'(e.to));
        end
      end
    end
  end
  // issue one aligned fetch acked after w wait cycles; dup re-pulses the token inside BUSY
  task automatic do_fetch(input logic [31:0] p, input int w, input logic [31:0] d, input bit dup);
    int n0;
    int r0;
    n0 = n_out;
    r0 = n_req;
    fif.pc = p;
    fif.fetch_pipeline_ctl_in = 1'b1;
    q.push_back('{d, p, 1'b0, 1'b0});
    tick;
    for (int i = 0; i <= w; i++) begin
      fif.fetch_pipeline_ctl_in = dup && i == 0;
      fif.pc = dup ? p + 32'd4 : p;
      if (i == w) begin
        fif.imem_ack = 1'b1;
        fif.imem_rdata = d;
      end
      @(negedge clk);
      chk("req_busy", 32'(fif.imem_req), 32'd1);
      chk("addr_busy", fif.imem_addr, p);
      tick;
    end
    fif.fetch_pipeline_ctl_in = 1'b0;
    fif.imem_ack = 1'b0;
    @(negedge clk);
    chk("req_done", 32'(fif.imem_req), 32'd0);
    tick;
    @(negedge clk);
    chk("ctl_one_cycle", 32'(fif.fetch_pipeline_ctl_out), 32'd0);
    chk("ctl_count", 32'(n_out), 32'(n0 + 1));
    chk("req_count", 32'(n_req), 32'(r0 + 1));
    tick;
  endtask
  initial begin
    int n;
    logic to_seen;
    rst = 1'b0;
    fif.pc = '0;
    fif.fetch_pipeline_ctl_in = 1'b0;
    fif.imem_ack = 1'b0;
    fif.imem_rdata = '0;
    @(negedge clk);
    chk("rst_req", 32'(fif.imem_req), 32'd0);
    chk("rst_addr", fif.imem_addr, 32'h0);
    chk("rst_instr", fif.instr, 32'h0000_0013);
    chk("rst_instr_pc", fif.instr_pc, 32'h0000_8000);
    chk("rst_ctl", 32'(fif.fetch_pipeline_ctl_out), 32'd0);
    chk("rst_mis", 32'(fif.misaligned), 32'd0);
    chk("rst_to", 32'(fif.timeout_err), 32'd0);
    tick;
    rst = 1'b1;
    tick;
    do_fetch(32'h0000_8000, 0, 32'h0000_0093, 1'b0);
    do_fetch(32'h0000_8004, 3, 32'h0010_0113, 1'b0);
    n = n_req;
    fif.pc = 32'h0000_8002;
    fif.fetch_pipeline_ctl_in = 1'b1;
    q.push_back('{32'h0000_0013, 32'h0000_8002, 1'b1, 1'b0});
    tick;
    fif.fetch_pipeline_ctl_in = 1'b0;
    @(negedge clk);
    chk("mis_no_req", 32'(fif.imem_req), 32'd0);
    tick;
    chk("mis_req_count", 32'(n_req), 32'(n));
    fif.imem_ack = 1'b1;
    fif.imem_rdata = 32'hDEAD_BEEF;
    tick;
    fif.imem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_instr", fif.instr, 32'h0000_0013);
    chk("stray_ack_req", 32'(n_req), 32'(n));
    tick;
    do_fetch(32'h0000_8008, 1, 32'h0020_0193, 1'b1);
    do_fetch(32'hFFFF_FFFC, 0, 32'h0030_0213, 1'b0);
    do_fetch(32'h0000_800C, 3, 32'h0040_0293, 1'b0);
    fif.pc = 32'h0000_8010;
    fif.fetch_pipeline_ctl_in = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    q.push_back('{32'h0000_0013, 32'h0000_8010, 1'b0, 1'b1});
`endif
    tick;
    fif.fetch_pipeline_ctl_in = 1'b0;
    n = 0;
    to_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!fif.imem_req) break;
      n++;
      to_seen = to_seen | fif.timeout_err;
      tick;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_req_cycles", 32'(n), 32'd4);
    tick;
    tick;
    fif.pc = 32'h0000_8014;
    fif.fetch_pipeline_ctl_in = 1'b1;
    tick;
    fif.fetch_pipeline_ctl_in = 1'b0;
`else
    chk("noto_req_cycles", 32'(n), 32'd300);
    chk("noto_timeout_err", 32'(to_seen), 32'd0);
`endif
    chk("busy_before_rst", 32'(fif.imem_req), 32'd1);
    n = n_out;
    fif.imem_ack = 1'b1;
    fif.imem_rdata = 32'h0050_0313;
    #2 rst = 1'b0;
    #1 chk("rst_async_req", 32'(fif.imem_req), 32'd0);
    @(posedge clk);
    #1 fif.imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_instr_pc", fif.instr_pc, 32'h0000_8000);
    chk("post_rst_instr", fif.instr, 32'h0000_0013);
    chk("post_rst_ctl", 32'(fif.fetch_pipeline_ctl_out), 32'd0);
    chk("post_rst_req", 32'(fif.imem_req), 32'd0);
    tick;
    tick;
    chk("post_rst_no_out", 32'(n_out), 32'(n));
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the rv32i core.
- Takes the PC register value from the write stage when that stage's pipeline-control token arrives, and issues a single-beat read on the instruction-memory port.
- Latches the returned word and forwards instruction + PC to decode, with a one-cycle pipeline-control token.
- Reader counterpart of the write stage's PC update: write produces the PC, fetch consumes it.

Parameters:
- RESET_PC, 32'h0000_8000, value of instr_pc after reset; matches the write-stage PC reset value.
- NOP_INSTR, 32'h0000_0013, instruction emitted on a faulted fetch (addi x0,x0,0).
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without imem_ack; only used with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pc  input  32  PC from write stage; sampled in the cycle fetch_pipeline_ctl_in=1.
- fetch_pipeline_ctl_in  input  1  start token from write stage (write_pipeline_ctl_out).
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned read address.
- imem_ack  input  1  memory response valid.
- imem_rdata  input  32  memory read data; valid when imem_ack=1.
- instr  output  32  fetched instruction.
- instr_pc  output  32  PC of instr.
- fetch_pipeline_ctl_out  output  1  one-cycle token to decode: instr/instr_pc valid.
- misaligned  output  1  pc[1:0]!=0 on the current fetch.
- timeout_err  output  1  fetch aborted by watchdog.

Behaviour:
- Reset (rst=0, async): state IDLE; imem_req=0; imem_addr=0; instr=NOP_INSTR; instr_pc=RESET_PC; fetch_pipeline_ctl_out=0; misaligned=0; timeout_err=0; watchdog count=0.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE, fetch_pipeline_ctl_in=1, pc[1:0]==0:
  - Capture pc into imem_addr and instr_pc.
  - imem_req<=1, misaligned<=0, timeout_err<=0; go to BUSY.
- IDLE, fetch_pipeline_ctl_in=1, pc[1:0]!=0:
  - No memory request.
  - instr_pc<=pc, instr<=NOP_INSTR, misaligned<=1; go to DONE.
- BUSY:
  - imem_req stays 1 and imem_addr stays stable until imem_ack is sampled 1.
  - imem_ack may be 1 in the first BUSY cycle.
  - On imem_ack=1: instr<=imem_rdata, imem_req<=0; go to DONE.
- DONE:
  - fetch_pipeline_ctl_out=1 for exactly this one cycle; instr, instr_pc and flags are stable.
  - Next state is IDLE unconditionally.
  - instr, instr_pc, misaligned and timeout_err hold until the next fetch starts.
- Latency: token in cycle N -> imem_req=1 in N+1.
  - Ack in N+1 -> fetch_pipeline_ctl_out=1 in N+2 (minimum).
  - Each ack-wait cycle adds 1.
  - Misaligned fetch: ctl_out=1 in N+1.
- fetch_pipeline_ctl_in while in BUSY or DONE: ignored, not queued.
- imem_ack while in IDLE or DONE: ignored; instr is unchanged.
- imem_rdata is sampled only in a BUSY cycle with imem_ack=1.
- Reset asserted mid-transaction: imem_req drops immediately (async); the in-flight response is discarded.
- pc=32'hFFFF_FFFC is a legal address; no wrap logic is applied.
- Fetch does not increment the PC; the next-PC computation lives downstream.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to BUSY, incremented each BUSY cycle with imem_ack=0.
  - When the count reaches TIMEOUT_CYCLES: imem_req<=0, instr<=NOP_INSTR, timeout_err<=1; go to DONE.
  - An imem_ack in the same cycle as the count reaching the limit takes priority: normal completion, timeout_err=0.
- Not defined:
  - No counter; BUSY waits indefinitely.
  - timeout_err is tied to 0 and the port remains present.

Test Plan:
- Reset release, pc=32'h0000_8000, ctl_in pulse; imem_ack in first BUSY cycle with rdata=32'h0000_0093 -> imem_req high 1 cycle with addr=32'h0000_8000; ctl_out 1 cycle later with instr=32'h0000_0093, instr_pc=32'h0000_8000.
- pc=32'h0000_8004, ack delayed 3 cycles, rdata=32'h0010_0113 -> imem_req/addr stable 4 cycles; ctl_out exactly 1 cycle; instr=32'h0010_0113.
- pc=32'h0000_8002 -> no imem_req; next cycle ctl_out=1, misaligned=1, instr=32'h0000_0013, instr_pc=32'h0000_8002.
- Second ctl_in pulse during BUSY, stray ack in IDLE with rdata=32'hDEAD_BEEF -> exactly one request issued; instr unchanged by the stray ack.
- rst driven low while BUSY (asynchronous to clk) -> imem_req=0 immediately; after release, instr_pc=32'h0000_8000, instr=32'h0000_0013, ctl_out=0.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 BUSY cycles; ctl_out=1 with timeout_err=1, instr=32'h0000_0013. Without the macro, req stays high for 300 cycles and timeout_err stays 0.
